// File: rtl/station_management_responder_if.sv
// MDIO line and register-file port bundle for station_management_responder.
// The responder uses the slave view; the station/register side uses master.
interface station_management_responder_if;
  logic        mdi;
  logic        mdo;
  logic        mdo_en;
  logic [4:0]  phy_address;
  logic [4:0]  reg_address;
  logic        reg_read_strobe;
  logic [15:0] reg_read_data;
  logic        reg_write_strobe;
  logic [15:0] reg_write_data;
  logic        frame_error;

  modport slave (
    input  mdi, phy_address, reg_read_data,
    output mdo, mdo_en, reg_address, reg_read_strobe,
           reg_write_strobe, reg_write_data, frame_error
  );

  modport master (
    output mdi, phy_address, reg_read_data,
    input  mdo, mdo_en, reg_address, reg_read_strobe,
           reg_write_strobe, reg_write_data, frame_error
  );
endinterface

// File: rtl/station_management_responder.sv
// Clause-22 MDIO PHY-side responder clocked by MDC; strobes an external 32x16 register file.
// Define STATION_MANAGEMENT_BROADCAST_EN to also accept writes addressed to PHY 0.
module station_management_responder #(
  parameter int PREAMBLE_MIN = 32
) (
  input logic clock,
  input logic reset,
  station_management_responder_if.slave bus
);

  typedef enum logic [2:0] {
    PREAMBLE,
    START,
    OPCODE,
    PHY_ADDRESS,
    REG_ADDRESS,
    TURNAROUND,
    DATA
  } state_t;

  state_t      r_state, w_nextState;
  logic [5:0]  r_onesCnt, w_onesCnt;
  logic [3:0]  r_bitCnt, w_bitCnt;
  logic        r_isRead, w_isRead;
  logic        r_matched, w_matched;
  logic [14:0] r_shift, w_shift;
  logic [4:0]  r_phyRx, w_phyRx;
  logic [15:0] r_rdShift, w_rdShift;
  logic        r_mdo, w_mdo;
  logic        r_mdoEn, w_mdoEn;
  logic [4:0]  r_regAddr, w_regAddr;
  logic        r_rdStb, w_rdStb;
  logic        r_wrStb, w_wrStb;
  logic [15:0] r_wrData, w_wrData;
  logic        r_frameErr, w_frameErr;

  logic [15:0] w_shiftIn;
  logic        w_match;

  assign w_shiftIn = {r_shift, bus.mdi};

  // Reads to the broadcast address are refused so several PHYs never drive the line together.
`ifdef STATION_MANAGEMENT_BROADCAST_EN
  assign w_match = r_isRead ? ((r_phyRx == bus.phy_address) && (r_phyRx != 5'd0))
                            : ((r_phyRx == bus.phy_address) || (r_phyRx == 5'd0));
`else
  assign w_match = (r_phyRx == bus.phy_address);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= PREAMBLE;
      r_onesCnt  <= 6'd0;
      r_bitCnt   <= 4'd0;
      r_isRead   <= 1'b0;
      r_matched  <= 1'b0;
      r_shift    <= 15'd0;
      r_phyRx    <= 5'd0;
      r_rdShift  <= 16'd0;
      r_mdo      <= 1'b0;
      r_mdoEn    <= 1'b0;
      r_regAddr  <= 5'd0;
      r_rdStb    <= 1'b0;
      r_wrStb    <= 1'b0;
      r_wrData   <= 16'd0;
      r_frameErr <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_onesCnt  <= w_onesCnt;
      r_bitCnt   <= w_bitCnt;
      r_isRead   <= w_isRead;
      r_matched  <= w_matched;
      r_shift    <= w_shift;
      r_phyRx    <= w_phyRx;
      r_rdShift  <= w_rdShift;
      r_mdo      <= w_mdo;
      r_mdoEn    <= w_mdoEn;
      r_regAddr  <= w_regAddr;
      r_rdStb    <= w_rdStb;
      r_wrStb    <= w_wrStb;
      r_wrData   <= w_wrData;
      r_frameErr <= w_frameErr;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_onesCnt   = 6'd0;
    w_bitCnt    = r_bitCnt + 4'd1;
    w_isRead    = r_isRead;
    w_matched   = r_matched;
    w_shift     = w_shiftIn[14:0];
    w_phyRx     = r_phyRx;
    w_rdShift   = r_rdShift;
    w_mdo       = r_mdo;
    w_mdoEn     = r_mdoEn;
    w_regAddr   = r_regAddr;
    w_rdStb     = 1'b0;
    w_wrStb     = 1'b0;
    w_wrData    = r_wrData;
    w_frameErr  = 1'b0;

    case (r_state)
      // The zero that ends a long-enough preamble is the first start bit.
      PREAMBLE: begin
        w_bitCnt = 4'd0;
        if (bus.mdi) begin
          w_onesCnt = (r_onesCnt >= 6'd32) ? r_onesCnt : r_onesCnt + 6'd1;
        end else if (r_onesCnt >= 6'(PREAMBLE_MIN)) begin
          w_nextState = START;
        end
      end

      START: begin
        w_bitCnt = 4'd0;
        if (bus.mdi) begin
          w_nextState = OPCODE;
        end else begin
          w_frameErr  = 1'b1;
          w_nextState = PREAMBLE;
        end
      end

      OPCODE: begin
        if (r_bitCnt == 4'd1) begin
          w_bitCnt = 4'd0;
          case ({r_shift[0], bus.mdi})
            2'b10: begin
              w_isRead    = 1'b1;
              w_nextState = PHY_ADDRESS;
            end
            2'b01: begin
              w_isRead    = 1'b0;
              w_nextState = PHY_ADDRESS;
            end
            default: begin
              w_frameErr  = 1'b1;
              w_nextState = PREAMBLE;
            end
          endcase
        end
      end

      PHY_ADDRESS: begin
        if (r_bitCnt == 4'd4) begin
          w_bitCnt    = 4'd0;
          w_phyRx     = w_shiftIn[4:0];
          w_nextState = REG_ADDRESS;
        end
      end

      REG_ADDRESS: begin
        if (r_bitCnt == 4'd4) begin
          w_bitCnt    = 4'd0;
          w_regAddr   = w_shiftIn[4:0];
          w_matched   = w_match;
          w_rdStb     = w_match && r_isRead;
          w_nextState = TURNAROUND;
        end
      end

      // Read data is captured while the strobe is up and driven from TA2 onward.
      TURNAROUND: begin
        if (r_bitCnt == 4'd0) begin
          if (r_isRead && r_matched) begin
            w_rdShift = bus.reg_read_data;
            w_mdoEn   = 1'b1;
            w_mdo     = 1'b0;
          end
        end else begin
          w_bitCnt    = 4'd0;
          w_nextState = DATA;
          if (!r_isRead && ({r_shift[0], bus.mdi} != 2'b10)) begin
            w_frameErr  = 1'b1;
            w_nextState = PREAMBLE;
          end else if (r_isRead && r_matched) begin
            w_mdo     = r_rdShift[15];
            w_rdShift = {r_rdShift[14:0], 1'b0};
          end
        end
      end

      DATA: begin
        if (r_isRead && r_matched) begin
          if (r_bitCnt == 4'd15) begin
            w_mdoEn = 1'b0;
            w_mdo   = 1'b0;
          end else begin
            w_mdo     = r_rdShift[15];
            w_rdShift = {r_rdShift[14:0], 1'b0};
          end
        end
        if (r_bitCnt == 4'd15) begin
          w_bitCnt    = 4'd0;
          w_nextState = PREAMBLE;
          if (!r_isRead && r_matched) begin
            w_wrData = w_shiftIn;
            w_wrStb  = 1'b1;
          end
        end
      end

      default: begin
        w_nextState = PREAMBLE;
        w_bitCnt    = 4'd0;
        w_mdoEn     = 1'b0;
        w_mdo       = 1'b0;
      end
    endcase
  end

  assign bus.mdo              = r_mdo;
  assign bus.mdo_en           = r_mdoEn;
  assign bus.reg_address      = r_regAddr;
  assign bus.reg_read_strobe  = r_rdStb;
  assign bus.reg_write_strobe = r_wrStb;
  assign bus.reg_write_data   = r_wrData;
  assign bus.frame_error      = r_frameErr;

endmodule

// File: tb/tb_station_management_responder.sv
// Directed bench for station_management_responder: table of whole MDIO frames plus a mid-read reset.
// Expected broadcast behaviour follows STATION_MANAGEMENT_BROADCAST_EN.
module tb_station_management_responder;

  localparam logic [4:0] MY_PHY = 5'h03;
`ifdef STATION_MANAGEMENT_BROADCAST_EN
  localparam int BCAST = 1;
`else
  localparam int BCAST = 0;
`endif

  logic clock = 1'b0;
  logic reset;

  station_management_responder_if bus();

  station_management_responder #(.PREAMBLE_MIN(32)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          ones;
    logic [1:0]  st;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  regA;
    logic [1:0]  ta;
    logic [15:0] data;
    logic [15:0] rdData;
    int          expRd;
    int          expWr;
    int          expEn;
    int          expErr;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  int total = 0;
  int bad = 0;

  logic frameBits[$];

  int rdCount, rdIdx, wrCount, wrIdx, enCount, enFirst, errCount;
  logic [4:0]  rdAddr, wrAddr;
  logic [15:0] wrData;
  logic [16:0] mdoWord;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One MDC period: new bit during low phase, outputs settle just after the rising edge.
  task automatic applyStimulus(input logic b);
    @(negedge clock);
    bus.mdi = b;
    @(posedge clock);
    #1;
  endtask

  task automatic buildFrame(input int ones, input logic [1:0] st, input logic [1:0] op,
                            input logic [4:0] phy, input logic [4:0] regA,
                            input logic [1:0] ta, input logic [15:0] data);
    frameBits.delete();
    for (int i = 0; i < ones; i++) frameBits.push_back(1'b1);
    for (int i = 1; i >= 0; i--) frameBits.push_back(st[i]);
    for (int i = 1; i >= 0; i--) frameBits.push_back(op[i]);
    for (int i = 4; i >= 0; i--) frameBits.push_back(phy[i]);
    for (int i = 4; i >= 0; i--) frameBits.push_back(regA[i]);
    for (int i = 1; i >= 0; i--) frameBits.push_back(ta[i]);
    for (int i = 15; i >= 0; i--) frameBits.push_back(data[i]);
    frameBits.push_back(1'b0);
  endtask

  task automatic clearObs();
    rdCount = 0; rdIdx = -1; wrCount = 0; wrIdx = -1;
    enCount = 0; enFirst = -1; errCount = 0;
    rdAddr = 5'd0; wrAddr = 5'd0; wrData = 16'd0; mdoWord = 17'd0;
  endtask

  // Register file model: data is only valid in the period the read strobe is high.
  task automatic runBits(input int n, input logic [15:0] rdData);
    for (int i = 0; i < n; i++) begin
      applyStimulus(frameBits[i]);
      if (bus.reg_read_strobe) begin
        rdCount++; rdIdx = i; rdAddr = bus.reg_address;
      end
      if (bus.reg_write_strobe) begin
        wrCount++; wrIdx = i; wrAddr = bus.reg_address; wrData = bus.reg_write_data;
      end
      if (bus.mdo_en) begin
        if (enFirst < 0) enFirst = i;
        enCount++;
        mdoWord = {mdoWord[15:0], bus.mdo};
      end
      if (bus.frame_error) errCount++;
      bus.reg_read_data = bus.reg_read_strobe ? rdData : 16'h0BAD;
    end
  endtask

  task automatic runVector(input int k);
    vec_t v;
    v = vecs[k];
    buildFrame(v.ones, v.st, v.op, v.phy, v.regA, v.ta, v.data);
    clearObs();
    runBits(frameBits.size(), v.rdData);
    checkOutput($sformatf("v%0d rdCount", k), rdCount, v.expRd);
    checkOutput($sformatf("v%0d wrCount", k), wrCount, v.expWr);
    checkOutput($sformatf("v%0d enCount", k), enCount, v.expEn);
    checkOutput($sformatf("v%0d errCount", k), errCount, v.expErr);
    if (v.expRd != 0) begin
      checkOutput($sformatf("v%0d rdIdx", k), rdIdx, v.ones + 13);
      checkOutput($sformatf("v%0d rdAddr", k), rdAddr, v.regA);
      checkOutput($sformatf("v%0d enFirst", k), enFirst, v.ones + 14);
      checkOutput($sformatf("v%0d mdoWord", k), mdoWord, {1'b0, v.rdData});
    end
    if (v.expWr != 0) begin
      checkOutput($sformatf("v%0d wrIdx", k), wrIdx, v.ones + 31);
      checkOutput($sformatf("v%0d wrAddr", k), wrAddr, v.regA);
      checkOutput($sformatf("v%0d wrData", k), wrData, v.data);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " mdo"}, bus.mdo, 1'b0);
    checkOutput({tag, " mdo_en"}, bus.mdo_en, 1'b0);
    checkOutput({tag, " rdStb"}, bus.reg_read_strobe, 1'b0);
    checkOutput({tag, " wrStb"}, bus.reg_write_strobe, 1'b0);
    checkOutput({tag, " regAddr"}, bus.reg_address, 5'd0);
    checkOutput({tag, " wrData"}, bus.reg_write_data, 16'd0);
    checkOutput({tag, " frameErr"}, bus.frame_error, 1'b0);
  endtask

  initial begin
    //          ones st     op     phy    reg    ta     data      rdData    rd wr     en  err
    vecs[0]  = '{32, 2'b01, 2'b10, 5'h03, 5'h05, 2'b11, 16'hFFFF, 16'hA5C3, 1, 0,     17, 0};
    vecs[1]  = '{32, 2'b01, 2'b01, 5'h03, 5'h1F, 2'b10, 16'h1234, 16'h0000, 0, 1,     0,  0};
    vecs[2]  = '{32, 2'b01, 2'b10, 5'h07, 5'h05, 2'b11, 16'hFFFF, 16'hA5C3, 0, 0,     0,  0};
    vecs[3]  = '{32, 2'b01, 2'b10, 5'h03, 5'h0A, 2'b11, 16'hFFFF, 16'h5A3C, 1, 0,     17, 0};
    vecs[4]  = '{31, 2'b01, 2'b10, 5'h03, 5'h05, 2'b11, 16'hFFFF, 16'hA5C3, 0, 0,     0,  0};
    vecs[5]  = '{32, 2'b00, 2'b10, 5'h03, 5'h05, 2'b11, 16'hFFFF, 16'hA5C3, 0, 0,     0,  1};
    vecs[6]  = '{32, 2'b01, 2'b11, 5'h03, 5'h05, 2'b10, 16'h1234, 16'h0000, 0, 0,     0,  1};
    vecs[7]  = '{32, 2'b01, 2'b00, 5'h03, 5'h05, 2'b10, 16'h1234, 16'h0000, 0, 0,     0,  1};
    vecs[8]  = '{32, 2'b01, 2'b01, 5'h03, 5'h05, 2'b11, 16'h1234, 16'h0000, 0, 0,     0,  1};
    vecs[9]  = '{32, 2'b01, 2'b01, 5'h07, 5'h05, 2'b10, 16'h4321, 16'h0000, 0, 0,     0,  0};
    vecs[10] = '{32, 2'b01, 2'b01, 5'h00, 5'h0C, 2'b10, 16'hBEEF, 16'h0000, 0, BCAST, 0,  0};
    vecs[11] = '{32, 2'b01, 2'b10, 5'h00, 5'h0C, 2'b11, 16'hFFFF, 16'h7777, 0, 0,     0,  0};
    vecs[12] = '{40, 2'b01, 2'b10, 5'h03, 5'h1E, 2'b11, 16'hFFFF, 16'h8001, 1, 0,     17, 0};
    vecs[13] = '{33, 2'b01, 2'b01, 5'h03, 5'h00, 2'b10, 16'hFFFF, 16'h0000, 0, 1,     0,  0};
    vecs[14] = '{20, 2'b01, 2'b10, 5'h03, 5'h05, 2'b11, 16'hFFFF, 16'hA5C3, 0, 0,     0,  0};

    reset = 1'b1;
    bus.mdi = 1'b1;
    bus.phy_address = MY_PHY;
    bus.reg_read_data = 16'h0BAD;
    #2 reset = 1'b0;
    repeat (3) applyStimulus(1'b1);
    checkResetOutputs("inReset");
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(1'b0);
    checkResetOutputs("afterReset");

    for (int k = 0; k < NVEC; k++) runVector(k);

    // Reset during period R+10 of a matched read must release the line at once.
    buildFrame(32, 2'b01, 2'b10, MY_PHY, 5'h11, 2'b11, 16'hFFFF);
    clearObs();
    runBits(32 + 13 + 10, 16'hC0DE);
    checkOutput("midRead enHigh", bus.mdo_en, 1'b1);
    checkOutput("midRead regAddr", bus.reg_address, 5'h11);
    #2 reset = 1'b0;
    #1;
    checkResetOutputs("midReadReset");
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    @(negedge clock);
    reset = 1'b1;

    // A fresh full-preamble read after the abort must complete normally.
    runVector(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
